pixel_write_arbiter: RTL and testbench

- Parametrised N-channel pixel-write arbiter; successor to the two-input foreground/background colour gate.
- Each channel (background, sprites, HUD, ...) pushes (x, y, colour) pixel writes into its own small FIFO via a valid/ready handshake.
- An arbiter drains one pixel per cycle to the VGA adapter's x/y/colour/plot inputs.
- Supports fixed-priority or round-robin arbitration, a transparent-colour skip, and a global plot gate.

---
 rtl/pixel_write_arbiter.sv | 166 ++++++++++++++++
 tb/tb_pixel_write_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_arbiter.sv
// N-channel pixel-write arbiter: per-channel FIFOs drained one pixel per
// cycle into registered VGA x/y/colour/plot outputs.
module pixel_write_arbiter #(
  parameter int NUM_CH             = 2,
  parameter int X_W                = 10,
  parameter int Y_W                = 9,
  parameter int C_W                = 3,
  parameter int DEPTH              = 4,
  parameter int RR_MODE            = 0,
  parameter int TRANSPARENT_EN     = 1,
  parameter int TRANSPARENT_COLOUR = 0
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [NUM_CH-1:0]     in_valid,
  output logic [NUM_CH-1:0]     in_ready,
  input  logic [NUM_CH*X_W-1:0] in_x,
  input  logic [NUM_CH*Y_W-1:0] in_y,
  input  logic [NUM_CH*C_W-1:0] in_colour,
  input  logic                  plot_enable,
  output logic [X_W-1:0]        oX,
  output logic [Y_W-1:0]        oY,
  output logic [C_W-1:0]        oColour,
  output logic                  oPlot,
  output logic [2:0]            grant_ch,
  output logic [NUM_CH-1:0]     fifo_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [C_W-1:0] TCOL = C_W'(TRANSPARENT_COLOUR);

  logic [X_W-1:0] xmem_q [NUM_CH][DEPTH];
  logic [Y_W-1:0] ymem_q [NUM_CH][DEPTH];
  logic [C_W-1:0] cmem_q [NUM_CH][DEPTH];

  logic [NUM_CH-1:0][PW-1:0] wr_q, wr_d;
  logic [NUM_CH-1:0][PW-1:0] rd_q, rd_d;
  logic [NUM_CH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [2:0]                rr_q, rr_d;

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [C_W-1:0] c_q, c_d;
  logic           plot_q, plot_d;
  logic [2:0]     g_q, g_d;

  logic [NUM_CH-1:0] push, pop, elig;
  logic              gnt_vld;
  logic [2:0]        gnt;
  logic [X_W-1:0]    hx;
  logic [Y_W-1:0]    hy;
  logic [C_W-1:0]    hc;

  always_comb begin : p_arb
    int j;
    j       = 0;
    elig    = '0;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = plot_enable && (cnt_q[i] != '0);
    end
    if (RR_MODE != 0) begin
      for (int k = 0; k < NUM_CH; k++) begin
        j = (int'(rr_q) + k) % NUM_CH;
        if (!gnt_vld && elig[j]) begin
          gnt_vld = 1'b1;
          gnt     = 3'(j);
        end
      end
    end else begin
      // ascending scan: the highest eligible index wins
      for (int i = 0; i < NUM_CH; i++) begin
        if (elig[i]) begin
          gnt_vld = 1'b1;
          gnt     = 3'(i);
        end
      end
    end
  end

  always_comb begin : p_fifo
    hx = '0;
    hy = '0;
    hc = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i]   = (cnt_q[i] != FULL);
      fifo_empty[i] = (cnt_q[i] == '0);
      push[i] = in_valid[i] && in_ready[i];
      pop[i]  = gnt_vld && (gnt == 3'(i));
      wr_d[i] = push[i] ? wr_q[i] + 1'b1 : wr_q[i];
      rd_d[i] = pop[i] ? rd_q[i] + 1'b1 : rd_q[i];
      unique case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
      if (pop[i]) begin
        hx = xmem_q[i][rd_q[i]];
        hy = ymem_q[i][rd_q[i]];
        hc = cmem_q[i][rd_q[i]];
      end
    end
  end

  always_comb begin : p_out
    rr_d   = rr_q;
    x_d    = x_q;
    y_d    = y_q;
    c_d    = c_q;
    g_d    = g_q;
    plot_d = 1'b0;
    if (gnt_vld) begin
      rr_d   = (int'(gnt) == NUM_CH - 1) ? 3'd0 : gnt + 3'd1;
      x_d    = hx;
      y_d    = hy;
      c_d    = hc;
      g_d    = gnt;
      // transparent pixels are consumed without a strobe
      plot_d = !((TRANSPARENT_EN != 0) && (hc == TCOL));
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) begin
        xmem_q[i][wr_q[i]] <= in_x[i*X_W +: X_W];
        ymem_q[i][wr_q[i]] <= in_y[i*Y_W +: Y_W];
        cmem_q[i][wr_q[i]] <= in_colour[i*C_W +: C_W];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      rr_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      c_q    <= '0;
      plot_q <= 1'b0;
      g_q    <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
      x_q    <= x_d;
      y_q    <= y_d;
      c_q    <= c_d;
      plot_q <= plot_d;
      g_q    <= g_d;
    end
  end

  assign oX       = x_q;
  assign oY       = y_q;
  assign oColour  = c_q;
  assign oPlot    = plot_q;
  assign grant_ch = g_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Bench for pixel_write_arbiter: a fixed-priority 2-channel and a
// round-robin 3-channel instance against a queue-based reference model.
module tb_pixel_write_arbiter;

  localparam int DEP = 4;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] c;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       vld [6];
  logic [9:0] px  [6];
  logic [8:0] py  [6];
  logic [2:0] pc  [6];
  logic       pe  [2];

  logic [1:0]  fp_valid, fp_ready, fp_empty;
  logic [19:0] fp_ix;
  logic [17:0] fp_iy;
  logic [5:0]  fp_ic;
  logic [9:0]  fp_x;
  logic [8:0]  fp_y;
  logic [2:0]  fp_c, fp_g;
  logic        fp_plot;

  logic [2:0]  rr_valid, rr_ready, rr_empty;
  logic [29:0] rr_ix;
  logic [26:0] rr_iy;
  logic [8:0]  rr_ic;
  logic [9:0]  rr_x;
  logic [8:0]  rr_y;
  logic [2:0]  rr_c, rr_g;
  logic        rr_plot;

  assign fp_valid = {vld[1], vld[0]};
  assign fp_ix    = {px[1], px[0]};
  assign fp_iy    = {py[1], py[0]};
  assign fp_ic    = {pc[1], pc[0]};
  assign rr_valid = {vld[5], vld[4], vld[3]};
  assign rr_ix    = {px[5], px[4], px[3]};
  assign rr_iy    = {py[5], py[4], py[3]};
  assign rr_ic    = {pc[5], pc[4], pc[3]};

  pixel_write_arbiter #(.NUM_CH(2), .DEPTH(DEP), .RR_MODE(0)) u_fp (
    .clock(clk), .resetn(resetn),
    .in_valid(fp_valid), .in_ready(fp_ready),
    .in_x(fp_ix), .in_y(fp_iy), .in_colour(fp_ic),
    .plot_enable(pe[0]),
    .oX(fp_x), .oY(fp_y), .oColour(fp_c), .oPlot(fp_plot),
    .grant_ch(fp_g), .fifo_empty(fp_empty)
  );

  pixel_write_arbiter #(.NUM_CH(3), .DEPTH(DEP), .RR_MODE(1)) u_rr (
    .clock(clk), .resetn(resetn),
    .in_valid(rr_valid), .in_ready(rr_ready),
    .in_x(rr_ix), .in_y(rr_iy), .in_colour(rr_ic),
    .plot_enable(pe[1]),
    .oX(rr_x), .oY(rr_y), .oColour(rr_c), .oPlot(rr_plot),
    .grant_ch(rr_g), .fifo_empty(rr_empty)
  );

  pix_t       q [6][$];
  logic [9:0] eX [2];
  logic [8:0] eY [2];
  logic [2:0] eC [2];
  logic [2:0] eG [2];
  logic       eP [2];
  int         rr [2];
  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) q[i].delete();
    for (int m = 0; m < 2; m++) begin
      eX[m] = '0; eY[m] = '0; eC[m] = '0;
      eG[m] = '0; eP[m] = 1'b0; rr[m] = 0;
    end
  endtask

  task automatic step(int m);
    int   n;
    int   g;
    bit   full [3];
    pix_t p;
    n = (m == 1) ? 3 : 2;
    g = -1;
    if (!resetn) return;
    for (int i = 0; i < n; i++) full[i] = (q[m*3+i].size() == DEP);
    if (pe[m]) begin
      if (m == 1) begin
        for (int k = 0; k < n; k++) begin
          int j;
          j = (rr[m] + k) % n;
          if (g < 0 && q[m*3+j].size() > 0) g = j;
        end
      end else begin
        for (int i = 0; i < n; i++) if (q[m*3+i].size() > 0) g = i;
      end
    end
    if (g >= 0) begin
      p = q[m*3+g].pop_front();
      eX[m] = p.x; eY[m] = p.y; eC[m] = p.c;
      eG[m] = 3'(g);
      eP[m] = (p.c != 3'd0);
      rr[m] = (g + 1) % n;
    end else begin
      eP[m] = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      if (vld[m*3+i] && !full[i]) begin
        p.x = px[m*3+i]; p.y = py[m*3+i]; p.c = pc[m*3+i];
        q[m*3+i].push_back(p);
      end
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      logic [25:0] ov, ev;
      logic [5:0]  of, ef;
      int          n;
      n = (m == 1) ? 3 : 2;
      if (m == 0) begin
        ov = {fp_plot, fp_g, fp_x, fp_y, fp_c};
        of = {1'b0, fp_empty, 1'b0, fp_ready};
      end else begin
        ov = {rr_plot, rr_g, rr_x, rr_y, rr_c};
        of = {rr_empty, rr_ready};
      end
      ev = {eP[m], eG[m], eX[m], eY[m], eC[m]};
      ef = '0;
      for (int i = 0; i < n; i++) begin
        ef[3+i] = (q[m*3+i].size() == 0);
        ef[i]   = (q[m*3+i].size() != DEP);
      end
      vectors++;
      assert (ov === ev) else begin
        miscompares++;
        $error("FAIL outputs dut=%0d observed=%h expected=%h", m, ov, ev);
      end
      vectors++;
      assert (of === ef) else begin
        miscompares++;
        $error("FAIL flags dut=%0d observed=%b expected=%b", m, of, ef);
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    step(0);
    step(1);
    #1;
    check_all();
  endtask

  task automatic idle();
    for (int i = 0; i < 6; i++) vld[i] = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vld[i] = 1'b0; px[i] = '0; py[i] = '0; pc[i] = '0;
    end
    pe[0] = 1'b0;
    pe[1] = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_plot", 32'(fp_plot), 0);
    chk("rst_empty", 32'(rr_empty), 7);
    @(negedge clk);
    resetn = 1'b1;

    // single pixel, 2-cycle latency
    pe[0] = 1'b1;
    vld[0] = 1'b1; px[0] = 10'd5; py[0] = 9'd7; pc[0] = 3'd3;
    cyc();
    chk("t1_early", 32'(fp_plot), 0);
    idle();
    cyc();
    chk("t1_plot", 32'(fp_plot), 1);
    chk("t1_xyc", {fp_g, fp_x, fp_y, fp_c}, {3'd0, 10'd5, 9'd7, 3'd3});
    cyc();
    chk("t1_drop", 32'(fp_plot), 0);

    // fixed priority: ch1 before ch0
    vld[0] = 1'b1; px[0] = 10'd11; pc[0] = 3'd1;
    vld[1] = 1'b1; px[1] = 10'd12; pc[1] = 3'd2;
    cyc();
    idle();
    cyc();
    chk("t2_first", {fp_plot, fp_g, fp_c}, {1'b1, 3'd1, 3'd2});
    cyc();
    chk("t2_second", {fp_plot, fp_g, fp_c}, {1'b1, 3'd0, 3'd1});
    chk("t2_empty", 32'(fp_empty), 3);

    // transparent pixel is consumed silently
    vld[0] = 1'b1; px[0] = 10'd20; pc[0] = 3'd0;
    cyc();
    px[0] = 10'd21; pc[0] = 3'd5;
    cyc();
    chk("t4_skip", {fp_plot, fp_empty[0]}, {1'b0, 1'b0});
    idle();
    cyc();
    chk("t4_plot", {fp_plot, fp_c}, {1'b1, 3'd5});

    // back-pressure with the plot gate closed
    pe[0] = 1'b0;
    for (int k = 0; k < DEP + 2; k++) begin
      vld[0] = 1'b1; px[0] = 10'(30 + k); pc[0] = 3'((k % 7) + 1);
      chk("t5_ready", 32'(fp_ready[0]), (k < DEP) ? 1 : 0);
      cyc();
      chk("t5_noplot", 32'(fp_plot), 0);
    end
    idle();
    cyc();
    pe[0] = 1'b1;
    for (int k = 0; k < DEP; k++) begin
      cyc();
      chk("t5_drain", {fp_plot, fp_x}, {1'b1, 10'(30 + k)});
    end
    cyc();
    chk("t5_done", {fp_plot, fp_empty[0]}, {1'b0, 1'b1});

    // round-robin order on a fresh reset
    @(negedge clk);
    resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    resetn = 1'b1;
    pe[1] = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        vld[3+i] = 1'b1; px[3+i] = 10'(40 + r*3 + i); pc[3+i] = 3'(i + 1);
      end
      cyc();
    end
    idle();
    pe[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("t3_grant", {rr_plot, rr_g}, {1'b1, 3'(k % 3)});
    end
    cyc();
    chk("t3_done", {rr_plot, rr_empty}, {1'b0, 3'b111});

    // asynchronous reset mid-stream
    pe[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vld[0] = 1'b1; px[0] = 10'(60 + k); py[0] = 9'd9; pc[0] = 3'd6;
      vld[1] = 1'b1; px[1] = 10'(70 + k); py[1] = 9'd8; pc[1] = 3'd7;
      cyc();
    end
    idle();
    chk("t6_live", 32'(fp_plot), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_async", {fp_plot, fp_x, fp_y, fp_c, fp_empty}, 0 | 2'b11);
    model_reset();
    check_all();
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t6_stale", 32'(fp_plot), 0);
    end

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 6; i++) begin
        vld[i] = 1'($urandom_range(0, 1));
        px[i]  = 10'($urandom);
        py[i]  = 9'($urandom);
        pc[i]  = 3'($urandom);
      end
      vld[2] = 1'b0;
      pe[0] = ($urandom_range(0, 3) != 0);
      pe[1] = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
